// File: rtl/pipe_front_ctrl_pkg.sv
// Shared constants for the fetch front end: IF/ID control codes, FSM states, reset PC.
package pipe_front_ctrl_pkg;

    typedef enum logic [1:0] {
        IFID_FLUSH = 2'b00,
        IFID_LOAD  = 2'b01,
        IFID_HOLD  = 2'b10,
        IFID_RSVD  = 2'b11
    } ifid_code_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_HOLD2 = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

endpackage

// File: rtl/pipe_front_ctrl_sat_counter16.sv
// 16-bit event counter that sticks at its maximum value instead of wrapping.
module sat_counter16
    import pipe_front_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            value <= 16'h0000;
        else if (enable && (value != CNT_MAX))
            value <= value + 16'd1;
    end

endmodule

// File: rtl/pipe_front_ctrl.sv
// Fetch-side PC and IF/ID register control with a one-cycle extended stall state.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_RUN   | normal operation; PC and IF/ID follow the hazard inputs
// ST_HOLD2 | second stall cycle of a load-use-branch; everything frozen,
//          | EX_Bubble asserted, back to ST_RUN after one cycle
module pipe_front_ctrl
    import pipe_front_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_next,
    input  logic [31:0] Inst_mem_out,
    input  logic [1:0]  IF_ID_Hazard,
    input  logic        PC_Hazard,
    input  logic        delay,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Inst,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_Valid,
    output logic        EX_Bubble,
    output logic [15:0] Stall_Cnt,
    output logic [15:0] Flush_Cnt,
    output logic        Code_Err
);

    state_t     state, state_nxt;
    ifid_code_t code;

    logic pc_load;
    logic ifid_load;
    logic ifid_flush;
    logic stall_inc;
    logic flush_inc;
    logic err_set;

    assign code = ifid_code_t'(IF_ID_Hazard);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (delay && PC_Hazard && (code == IFID_HOLD)) state_nxt = ST_HOLD2;
            ST_HOLD2: state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // Flush wins over load/hold for IF/ID; PC hold is decided independently.
    always_comb begin
        pc_load    = 1'b0;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        err_set    = 1'b0;
        EX_Bubble  = 1'b0;
        case (state)
            ST_RUN: begin
                pc_load    = !PC_Hazard;
                stall_inc  = PC_Hazard;
                ifid_load  = (code == IFID_LOAD);
                ifid_flush = (code == IFID_FLUSH);
                flush_inc  = (code == IFID_FLUSH);
                err_set    = (code == IFID_RSVD);
            end
            ST_HOLD2: begin
                stall_inc = 1'b1;
                EX_Bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC          <= RESET_PC;
            IF_ID_Inst  <= 32'h0;
            IF_ID_PC4   <= 32'h0;
            IF_ID_Valid <= 1'b0;
            Code_Err    <= 1'b0;
        end else begin
            if (pc_load)
                PC <= PC_next;
            if (ifid_flush) begin
                IF_ID_Inst  <= 32'h0;
                IF_ID_PC4   <= 32'h0;
                IF_ID_Valid <= 1'b0;
            end else if (ifid_load) begin
                IF_ID_Inst  <= Inst_mem_out;
                IF_ID_PC4   <= PC + 32'd4;
                IF_ID_Valid <= 1'b1;
            end
            if (err_set)
                Code_Err <= 1'b1;
        end
    end

    sat_counter16 u_stall_cnt (
        .clk    (clk),
        .reset  (reset),
        .enable (stall_inc),
        .value  (Stall_Cnt)
    );

    sat_counter16 u_flush_cnt (
        .clk    (clk),
        .reset  (reset),
        .enable (flush_inc),
        .value  (Flush_Cnt)
    );

endmodule

// File: doc/pipe_front_ctrl.md
PIPE_FRONT_CTRL -- requirements
Module: pipe_front_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: PC_next  input  32  next-PC candidate from the fetch/branch mux.
REQ-004 SHALL have port: Inst_mem_out  input  32  instruction fetched at the current PC.
REQ-005 SHALL have port: IF_ID_Hazard  input  2  IF/ID control code: 00 flush, 01 load, 10 hold, 11 reserved.
REQ-006 SHALL have port: PC_Hazard  input  1  1 = hold PC this cycle.
REQ-007 SHALL have port: delay  input  1  1 = the requested stall lasts two cycles (load followed by dependent branch).
REQ-008 SHALL have port: PC  output  32  current fetch address.
REQ-009 SHALL have port: IF_ID_Inst  output  32  registered instruction presented to decode.
REQ-010 SHALL have port: IF_ID_PC4  output  32  registered PC+4 of IF_ID_Inst.
REQ-011 SHALL have port: IF_ID_Valid  output  1  1 = IF_ID_Inst is a real instruction; 0 = bubble.
REQ-012 SHALL have port: EX_Bubble  output  1  1 = decode must inject a bubble into ID/EX this cycle (extra stall cycle).
REQ-013 SHALL have port: Stall_Cnt  output  16  saturating count of cycles in which the PC was held.
REQ-014 SHALL have port: Flush_Cnt  output  16  saturating count of IF/ID flushes.
REQ-015 SHALL have port: Code_Err  output  1  sticky flag, set on any reserved IF/ID code.

Function
REQ-016 SHALL implement a two-state FSM, RUN and HOLD2, and leave reset in RUN.
REQ-017 SHALL, in RUN with PC_Hazard=0, load PC <= PC_next at the clock edge.
REQ-018 SHALL, in RUN with PC_Hazard=1, keep PC unchanged.
REQ-019 SHALL, in RUN with code 01, load IF_ID_Inst <= Inst_mem_out, IF_ID_PC4 <= PC+4 (modulo 2^32) and IF_ID_Valid <= 1.
REQ-020 SHALL, in RUN with code 00, load IF_ID_Inst <= 0, IF_ID_PC4 <= 0 and IF_ID_Valid <= 0.
REQ-021 SHALL, in RUN with code 10, hold all IF/ID outputs unchanged.
REQ-022 SHALL treat code 11 as a hold and set Code_Err, which clears only on reset.
REQ-023 SHALL transition RUN->HOLD2 when delay=1, PC_Hazard=1 and code=10 are all present in the same cycle; delay is ignored in every other combination.
REQ-024 SHALL, in HOLD2, hold PC and all IF/ID outputs and ignore all hazard inputs, then return to RUN after exactly one cycle.
REQ-025 SHALL drive EX_Bubble=1 combinationally only while in HOLD2.
REQ-026 SHALL increment Stall_Cnt once per cycle in which the PC is held: RUN with PC_Hazard=1, and every HOLD2 cycle.
REQ-027 SHALL increment Flush_Cnt once per RUN cycle with code 00.
REQ-028 SHALL saturate both counters at 16'hFFFF with no wrap.
REQ-029 SHALL let PC wrap naturally from 32'hFFFFFFFC to 0 with no flag.
REQ-030 SHALL give flush (00) precedence over PC_Hazard for the IF/ID update; the PC hold is still honoured in the same cycle.

Reset
REQ-031 SHALL, while reset=0, force: PC=32'h00000000, IF_ID_Inst=0, IF_ID_PC4=0, IF_ID_Valid=0, EX_Bubble=0, Stall_Cnt=0, Flush_Cnt=0, Code_Err=0, state=RUN, asynchronously.
REQ-032 SHALL abandon HOLD2 when reset is asserted while in it; the first post-reset cycle is a normal RUN cycle.

Structure
REQ-033 SHALL place the IF/ID code constants (FLUSH=00, LOAD=01, HOLD=10), the FSM state encoding and the reset PC value in a shared package also used by the hazard logic.
REQ-034 SHALL instantiate one sub-module, sat_counter16 (enable, value, saturate), twice; all other logic stays flat.

Verification
REQ-035 SHALL cover: code=01, PC_Hazard=0, PC=0x10, PC_next=0x14, Inst=0x8C080000 -> next cycle PC=0x14, IF_ID_Inst=0x8C080000, IF_ID_PC4=0x14, Valid=1.
REQ-036 SHALL cover: code=10, PC_Hazard=1, delay=1 for one cycle -> PC and IF/ID frozen for 2 cycles, EX_Bubble=1 in the second cycle only, Stall_Cnt=2.
REQ-037 SHALL cover: code=00 with PC_Hazard=1 -> IF_ID_Valid=0, IF_ID_Inst=0, PC unchanged, Flush_Cnt=1, Stall_Cnt=1.
REQ-038 SHALL cover: code=11 once, then code=01 -> IF/ID held in the 11 cycle, Code_Err=1 and remaining 1 afterwards.
REQ-039 SHALL cover: reset asserted during HOLD2 -> all outputs at reset values immediately, EX_Bubble=0, normal RUN load on the first cycle after release.
REQ-040 SHALL cover: PC_Hazard=1 held for 70000 cycles -> Stall_Cnt=16'hFFFF with no wrap.
